// File: rtl/nvram_access_arbiter.sv
// Arbitrates hiscore (req0) and nvram (req1) access to a shared game RAM port while the core CPU is paused.
// Optional pause-acknowledge timeout is enabled by defining NVRAM_ACCESS_ARBITER_TIMEOUT_EN.
module nvram_access_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned PAUSEPAD = 4,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    input  logic [7:0]    d0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    input  logic [7:0]    d1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [7:0]    q,
    input  logic          paused,
    output logic          pause_cpu,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_d,
    input  logic [7:0]    ram_q,
    output logic          timeout_err
);

    localparam int unsigned CW = (PAUSEPAD < 2) ? 1 : $clog2(PAUSEPAD + 1);
    localparam logic [CW-1:0] PAD = CW'(PAUSEPAD);
    localparam logic [CW-1:0] ONE = CW'(1);

    // The pause-acknowledge counter is 16 bits wide.
    if (TIMEOUT > 65535) begin : g_timeout_range
        $error("TIMEOUT exceeds the 16-bit pause-acknowledge counter");
    end

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        SETTLE,
        GRANT,
        HANDOVER,
        RELEASE
    } state_t;

    state_t        state, state_n;
    logic          gnt0_n, gnt1_n, pause_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          prio, prio_n;
    logic          pick0, pick1;

`ifdef NVRAM_ACCESS_ARBITER_TIMEOUT_EN
    logic [15:0] to_cnt, to_cnt_n;
    logic        terr_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= to_cnt_n;
            timeout_err <= terr_n;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            pause_cpu <= 1'b0;
            cnt       <= '0;
            prio      <= 1'b0;
        end else begin
            state     <= state_n;
            gnt0      <= gnt0_n;
            gnt1      <= gnt1_n;
            pause_cpu <= pause_n;
            cnt       <= cnt_n;
            prio      <= prio_n;
        end
    end

    // prio=1 means requester 1 wins a tie; flips to the other side after every grant.
    always_comb begin
        pick0   = req0 & (~req1 | ~prio);
        pick1   = req1 & (~req0 | prio);
        state_n = state;
        gnt0_n  = gnt0;
        gnt1_n  = gnt1;
        pause_n = pause_cpu;
        cnt_n   = cnt;
        prio_n  = prio;
`ifdef NVRAM_ACCESS_ARBITER_TIMEOUT_EN
        to_cnt_n = '0;
        terr_n   = timeout_err;
`endif
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    pause_n = 1'b1;
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (paused) begin
                    cnt_n   = PAD;
                    state_n = SETTLE;
                end
`ifdef NVRAM_ACCESS_ARBITER_TIMEOUT_EN
                else if (32'(to_cnt) + 32'd1 >= 32'(TIMEOUT)) begin
                    terr_n  = 1'b1;
                    pause_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    to_cnt_n = to_cnt + 16'd1;
                end
`endif
            end
            SETTLE: begin
                if (cnt <= ONE) begin
                    gnt0_n = pick0;
                    gnt1_n = pick1;
                    if (pick0 | pick1) begin
                        prio_n  = pick0;
                        state_n = GRANT;
                    end else begin
                        cnt_n   = PAD;
                        state_n = RELEASE;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            GRANT: begin
                if ((gnt0 & ~req0) | (gnt1 & ~req1)) begin
                    gnt0_n  = 1'b0;
                    gnt1_n  = 1'b0;
                    state_n = HANDOVER;
                end
            end
            HANDOVER: begin
                gnt0_n = pick0;
                gnt1_n = pick1;
                if (pick0 | pick1) begin
                    prio_n  = pick0;
                    state_n = GRANT;
                end else begin
                    cnt_n   = PAD;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                // A late request keeps the CPU paused and is served without re-settling.
                if (req0 | req1) begin
                    state_n = HANDOVER;
                end else if (cnt <= ONE) begin
                    pause_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: begin
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
                pause_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // Zero-latency RAM port mux driven by the registered grants.
    always_comb begin
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        if (gnt0) begin
            ram_addr = addr0;
            ram_d    = d0;
            ram_we   = we0;
        end else if (gnt1) begin
            ram_addr = addr1;
            ram_d    = d1;
            ram_we   = we1;
        end
    end

    assign q = ram_q;

endmodule

// File: tb/tb_nvram_access_arbiter.sv
// Directed bench for nvram_access_arbiter (PAUSEPAD=4, TIMEOUT=10); the timeout scenario runs when
// NVRAM_ACCESS_ARBITER_TIMEOUT_EN is defined.
module tb_nvram_access_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1, we0, we1, paused;
    logic [7:0] addr0, addr1, d0, d1, ram_q;
    logic       gnt0, gnt1, pause_cpu, ram_we, timeout_err;
    logic [7:0] q, ram_addr, ram_d;

    int checks = 0;
    int errors = 0;

    nvram_access_arbiter #(.AW(8), .PAUSEPAD(4), .TIMEOUT(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .addr0(addr0), .we0(we0), .d0(d0),
        .req1(req1), .addr1(addr1), .we1(we1), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .q(q),
        .paused(paused), .pause_cpu(pause_cpu),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; paused = 0;
        addr0 = 8'h00; addr1 = 8'h00; d0 = 8'h00; d1 = 8'h00; ram_q = 8'h00;
        tick(); tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1); end
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", pause_cpu); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_d !== 8'h00) begin errors++; $display("FAIL reset_ram: got we=%b a=%h d=%h expected 0/00/00", ram_we, ram_addr, ram_d); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_grant();
        req0 = 1; addr0 = 8'h12; we0 = 1; d0 = 8'hA5;
        tick();
        checks++; if (pause_cpu !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL single_pause: got pause=%b gnt0=%b expected 1/0", pause_cpu, gnt0); end
        repeat (3) tick();
        paused = 1;
        repeat (4) tick();
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL single_early_gnt: got %b expected 0", gnt0); end
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt: got %b%b expected 10", gnt0, gnt1); end
        checks++; if (ram_addr !== 8'h12 || ram_we !== 1'b1 || ram_d !== 8'hA5) begin errors++; $display("FAIL single_ram: got a=%h we=%b d=%h expected 12/1/a5", ram_addr, ram_we, ram_d); end
        addr0 = 8'h34; we0 = 0; ram_q = 8'h5A;
        #1;
        checks++; if (ram_addr !== 8'h34 || ram_we !== 1'b0 || q !== 8'h5A) begin errors++; $display("FAIL single_comb: got a=%h we=%b q=%h expected 34/0/5a", ram_addr, ram_we, q); end
        req0 = 0; we0 = 1;
        tick();
        checks++; if (gnt0 !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL drop_gnt: got gnt0=%b pause=%b expected 0/1", gnt0, pause_cpu); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_d !== 8'h00) begin errors++; $display("FAIL drop_ram: got we=%b a=%h d=%h expected 0/00/00", ram_we, ram_addr, ram_d); end
        tick();
        repeat (3) tick();
        checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL release_hold: got %b expected 1", pause_cpu); end
        tick();
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL release_end: got %b expected 0", pause_cpu); end
        paused = 0; we0 = 0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        paused = 1; req0 = 1; req1 = 1;
        addr0 = 8'h11; d0 = 8'h01; we0 = 1; addr1 = 8'h22; d1 = 8'h02; we1 = 0;
        repeat (5) tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL rr_settle: got %b%b pause=%b expected 00/1", gnt0, gnt1, pause_cpu); end
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rr_first: got %b%b expected 10", gnt0, gnt1); end
        checks++; if (ram_addr !== 8'h11 || ram_d !== 8'h01 || ram_we !== 1'b1) begin errors++; $display("FAIL rr_ram0: got a=%h d=%h we=%b expected 11/01/1", ram_addr, ram_d, ram_we); end
        req0 = 0;
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL rr_handover: got %b%b pause=%b expected 00/1", gnt0, gnt1, pause_cpu); end
        tick();
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL rr_second: got %b%b pause=%b expected 01/1", gnt0, gnt1, pause_cpu); end
        checks++; if (ram_addr !== 8'h22 || ram_d !== 8'h02 || ram_we !== 1'b0) begin errors++; $display("FAIL rr_ram1: got a=%h d=%h we=%b expected 22/02/0", ram_addr, ram_d, ram_we); end
        req0 = 1;
        repeat (3) tick();
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL rr_hold: got %b%b expected 01", gnt0, gnt1); end
        req1 = 0;
        tick(); tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rr_back0: got %b%b expected 10", gnt0, gnt1); end
        req1 = 1; req0 = 0;
        tick(); tick();
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL rr_back1: got %b%b expected 01", gnt0, gnt1); end
        req1 = 0;
        repeat (10) tick();
        checks++; if (pause_cpu !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL rr_idle: got pause=%b gnt=%b%b expected 0/00", pause_cpu, gnt0, gnt1); end
        paused = 0; we0 = 0;
    endtask

    task automatic test_release_abort();
        logic held;
        paused = 1; req0 = 1; addr0 = 8'h40;
        repeat (6) tick();
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL abort_gnt: got %b expected 1", gnt0); end
        req0 = 0;
        held = 1'b1;
        repeat (4) begin tick(); held &= pause_cpu; end
        req0 = 1;
        tick(); held &= pause_cpu;
        checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL abort_handover: got %b expected 0", gnt0); end
        tick(); held &= pause_cpu;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL abort_regrant: got %b expected 1", gnt0); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL abort_pause_drop: got %b expected 1", held); end
        req0 = 0;
        repeat (5) tick();
        checks++; if (pause_cpu !== 1'b1) begin errors++; $display("FAIL abort_pad: got %b expected 1", pause_cpu); end
        tick();
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL abort_end: got %b expected 0", pause_cpu); end
        paused = 0;
        tick();
    endtask

    task automatic test_settle_drop();
        logic any_gnt;
        paused = 1; req1 = 1;
        tick(); tick();
        req1 = 0;
        any_gnt = 1'b0;
        repeat (7) begin tick(); any_gnt |= gnt0 | gnt1; end
        checks++; if (any_gnt !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL settle_drop: got gnt=%b pause=%b expected 0/1", any_gnt, pause_cpu); end
        tick();
        checks++; if (pause_cpu !== 1'b0) begin errors++; $display("FAIL settle_drop_end: got %b expected 0", pause_cpu); end
        paused = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        paused = 1; req1 = 1; we1 = 1;
        repeat (6) tick();
        checks++; if (gnt1 !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL mid_gnt: got gnt1=%b we=%b expected 1/1", gnt1, ram_we); end
        reset_n = 0;
        tick();
        checks++; if (gnt1 !== 1'b0 || pause_cpu !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_reset: got gnt1=%b pause=%b we=%b expected 0/0/0", gnt1, pause_cpu, ram_we); end
        req1 = 0; we1 = 0; paused = 0; reset_n = 1;
        tick();
    endtask

    task automatic test_timeout();
`ifdef NVRAM_ACCESS_ARBITER_TIMEOUT_EN
        paused = 0; req0 = 1;
        tick();
        repeat (9) tick();
        checks++; if (pause_cpu !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_wait: got pause=%b terr=%b expected 1/0", pause_cpu, timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b1 || pause_cpu !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL to_fire: got terr=%b pause=%b gnt0=%b expected 1/0/0", timeout_err, pause_cpu, gnt0); end
        tick();
        checks++; if (pause_cpu !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_restart: got pause=%b terr=%b expected 1/1", pause_cpu, timeout_err); end
        req0 = 0; reset_n = 0;
        tick();
        checks++; if (timeout_err !== 1'b0 || pause_cpu !== 1'b0) begin errors++; $display("FAIL to_clear: got terr=%b pause=%b expected 0/0", timeout_err, pause_cpu); end
        reset_n = 1;
        tick();
`else
        paused = 0; req0 = 1;
        repeat (30) tick();
        checks++; if (pause_cpu !== 1'b1 || timeout_err !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL no_timeout: got pause=%b terr=%b gnt0=%b expected 1/0/0", pause_cpu, timeout_err, gnt0); end
        req0 = 0;
        do_reset();
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_release_abort();
        test_settle_drop();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
